// File: rtl/moore_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : moore_seq_pkg
// Description : Shared constants and next-state function for the
//               parametrised Moore sequence detector.
// Revision    : 1.0 - initial release
// ============================================================================
package moore_seq_pkg;

    // Widest pattern the next-state function is written to handle
    localparam int MAX_PAT_W = 16;
    // Idle state: no prefix bits matched
    localparam int S0 = 0;

    // Bits needed to encode states S0..S_PAT_W
    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // KMP-style transition. The string seen so far is prefix_k followed by b.
    // Return the longest j <= pat_w whose prefix_j equals the last j bits of
    // that string. pat is right-aligned; bit pat_w-1 is the first pattern bit.
    function automatic logic [4:0] prefix_next(input logic [15:0] pat,
                                               input int          pat_w,
                                               input int          k,
                                               input logic        b);
        int   best;
        int   idx;
        logic ok;
        logic sbit;
        best = 0;
        for (int j = 1; j <= MAX_PAT_W; j++) begin
            if (j <= pat_w && j <= k + 1) begin
                ok = 1'b1;
                for (int m = 0; m < MAX_PAT_W; m++) begin
                    if (m < j) begin
                        idx = k + 1 - j + m;
                        if (idx == k) sbit = b;
                        else          sbit = pat[4'(pat_w - 1 - idx)];
                        if (sbit != pat[4'(pat_w - 1 - m)]) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return 5'(best);
    endfunction

endpackage
`default_nettype wire

// File: rtl/moore_seq_next.sv
`default_nettype none
// ============================================================================
// Module      : moore_seq_next
// Description : Combinational next-state table for every state S0..S_PAT_W
//               and both input values, derived from the pattern register.
// Revision    : 1.0 - initial release
// ============================================================================
module moore_seq_next
    import moore_seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int SW    = 3
) (
    input  logic [PAT_W-1:0]         i_pat,
    output logic [PAT_W:0][SW-1:0]   o_nxt0,
    output logic [PAT_W:0][SW-1:0]   o_nxt1
);

    logic [15:0] w_pat_ext;

    assign w_pat_ext = 16'(i_pat);

    // One table row per current state; column chosen later by the input bit
    generate
        for (genvar k = 0; k <= PAT_W; k++) begin : g_state
            assign o_nxt0[k] = SW'(prefix_next(w_pat_ext, PAT_W, k, 1'b0));
            assign o_nxt1[k] = SW'(prefix_next(w_pat_ext, PAT_W, k, 1'b1));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/moore_seq_detector_p.sv
`default_nettype none
// ============================================================================
// Module      : moore_seq_detector_p
// Description : Parametrised Moore serial sequence detector with runtime
//               loadable pattern, selectable overlap, bit history and a
//               saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module moore_seq_detector_p
    import moore_seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               HIST_W  = 5,
    parameter int               CNT_W   = 8,
    localparam int              SW      = state_w(PAT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              inp,
    input  logic              pat_load,
    input  logic [PAT_W-1:0]  pat_in,
    output logic              outp,
    output logic [SW-1:0]     state,
    output logic [HIST_W-1:0] stack,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat
);

    localparam logic [SW-1:0] C_S0    = SW'(S0);
    localparam logic [SW-1:0] C_SFULL = SW'(PAT_W);

    logic [PAT_W-1:0]       r_pat;
    logic [SW-1:0]          r_state;
    logic [SW-1:0]          w_state_nxt;
    logic [SW-1:0]          w_k;
    logic [SW-1:0]          w_nxt;
    logic [PAT_W:0][SW-1:0] w_nxt0;
    logic [PAT_W:0][SW-1:0] w_nxt1;
    logic [HIST_W-1:0]      r_stack;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    moore_seq_next #(
        .PAT_W (PAT_W),
        .SW    (SW)
    ) u_next (
        .i_pat  (r_pat),
        .o_nxt0 (w_nxt0),
        .o_nxt1 (w_nxt1)
    );

    // Table lookup; without overlap a completed match restarts from S0
    always_comb begin
        w_k = r_state;
        if (OVERLAP == 0 && r_state == C_SFULL) w_k = C_S0;
        w_nxt = inp ? w_nxt1[w_k] : w_nxt0[w_k];
    end

    // Next state and counter; a pattern load overrides the sampled bit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (pat_load) begin
            w_state_nxt = C_S0;
            w_cnt_nxt   = '0;
        end else if (en) begin
            w_state_nxt = w_nxt;
            if (w_nxt == C_SFULL && !(&r_cnt)) w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // State and match counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= C_S0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pattern register, reloadable at run time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_pat <= PATTERN;
        else if (pat_load) r_pat <= pat_in;
    end

    // Input history, newest bit in position 0; shifts even during a load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    r_stack <= '0;
        else if (en) r_stack <= {r_stack[HIST_W-2:0], inp};
    end

    assign outp      = (r_state == C_SFULL);
    assign state     = r_state;
    assign stack     = r_stack;
    assign match_cnt = r_cnt;
    assign cnt_sat   = &r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_detector_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_seq_detector_p
// Description : Scoreboard bench for moore_seq_detector_p. Three instances
//               (default, no-overlap, 2-bit counter with 1111 pattern) share
//               the stimulus; directed expectations are queued and a
//               monitor process pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_seq_detector_p;

    typedef struct {
        string      name;
        int         which;
        logic       outp;
        logic [2:0] state;
        logic [7:0] cnt;
        logic [4:0] stack;
        logic       chk_stack;
        logic       sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       inp = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;

    logic       outp_m, outp_n, outp_s;
    logic [2:0] state_m, state_n, state_s;
    logic [4:0] stack_m, stack_n, stack_s;
    logic [7:0] cnt_m, cnt_n;
    logic [1:0] cnt_s;
    logic       sat_m, sat_n, sat_s;

    exp_t q[$];
    event e_push;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    moore_seq_detector_p #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .HIST_W(5), .CNT_W(8)) dut_m (
        .clk(clk), .rst(rst), .en(en), .inp(inp), .pat_load(pat_load), .pat_in(pat_in),
        .outp(outp_m), .state(state_m), .stack(stack_m), .match_cnt(cnt_m), .cnt_sat(sat_m));

    moore_seq_detector_p #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .HIST_W(5), .CNT_W(8)) dut_n (
        .clk(clk), .rst(rst), .en(en), .inp(inp), .pat_load(pat_load), .pat_in(pat_in),
        .outp(outp_n), .state(state_n), .stack(stack_n), .match_cnt(cnt_n), .cnt_sat(sat_n));

    moore_seq_detector_p #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1), .HIST_W(5), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .inp(inp), .pat_load(pat_load), .pat_in(pat_in),
        .outp(outp_s), .state(state_s), .stack(stack_s), .match_cnt(cnt_s), .cnt_sat(sat_s));

    // Monitor: drain the scoreboard whenever expectations are posted
    initial begin
        exp_t       e;
        logic       a_o;
        logic [2:0] a_st;
        logic [7:0] a_c;
        logic [4:0] a_sk;
        logic       a_sat;
        logic       bad;
        forever begin
            @(e_push);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.which)
                    0: begin a_o = outp_m; a_st = state_m; a_c = cnt_m; a_sk = stack_m; a_sat = sat_m; end
                    1: begin a_o = outp_n; a_st = state_n; a_c = cnt_n; a_sk = stack_n; a_sat = sat_n; end
                    default: begin a_o = outp_s; a_st = state_s; a_c = {6'b0, cnt_s}; a_sk = stack_s; a_sat = sat_s; end
                endcase
                bad = (a_o !== e.outp) || (a_st !== e.state) || (a_c !== e.cnt) ||
                      (a_sat !== e.sat) || (e.chk_stack && (a_sk !== e.stack));
                n_checks++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s: got outp=%0b state=%0d cnt=%0d stack=%05b sat=%0b, expected outp=%0b state=%0d cnt=%0d stack=%05b sat=%0b",
                             e.name, a_o, a_st, a_c, a_sk, a_sat, e.outp, e.state, e.cnt, e.stack, e.sat);
                end
            end
        end
    end

    task automatic expect_dut(input string nm, input int w, input logic o, input int st,
                              input int c, input int stk, input logic ck, input logic sat);
        exp_t e;
        e.name = nm; e.which = w; e.outp = o; e.state = 3'(st); e.cnt = 8'(c);
        e.stack = 5'(stk); e.chk_stack = ck; e.sat = sat;
        q.push_back(e);
        -> e_push;
    endtask

    // One clock edge of stimulus; outputs are settled 1 time unit later
    task automatic step(input logic e, input logic b, input logic pl, input logic [3:0] pi);
        @(negedge clk);
        en = e; inp = b; pat_load = pl; pat_in = pi;
        @(posedge clk);
        #1;
        en = 1'b0; pat_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int s1[4];
        int s2m[7];
        int s2n[7];
        // ---- Reset state (checked while reset is held) ----
        #2;
        expect_dut("reset_main", 0, 0, 0, 0, 0, 1, 0);
        expect_dut("reset_noovl", 1, 0, 0, 0, 0, 1, 0);
        expect_dut("reset_sat", 2, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;

        // ---- 1. Default pattern 1011 ----
        s1 = '{1, 2, 3, 4};
        step(1, 1, 0, 0); expect_dut("t1_e1", 0, 0, s1[0], 0, 5'b00001, 1, 0);
        step(1, 0, 0, 0); expect_dut("t1_e2", 0, 0, s1[1], 0, 5'b00010, 1, 0);
        step(1, 1, 0, 0); expect_dut("t1_e3", 0, 0, s1[2], 0, 5'b00101, 1, 0);
        step(1, 1, 0, 0); expect_dut("t1_e4", 0, 1, s1[3], 1, 5'b01011, 1, 0);

        // ---- 3. Runtime load (continues from S4, count 1); load edge has en=1 ----
        step(1, 0, 1, 4'b0011); expect_dut("t3_load", 0, 0, 0, 0, 5'b10110, 1, 0);
        step(1, 0, 0, 0); expect_dut("t3_a1", 0, 0, 1, 0, 5'b01100, 1, 0);
        step(1, 0, 0, 0); expect_dut("t3_a2", 0, 0, 2, 0, 5'b11000, 1, 0);
        step(1, 1, 0, 0); expect_dut("t3_a3", 0, 0, 3, 0, 5'b10001, 1, 0);
        step(1, 1, 0, 0); expect_dut("t3_a4", 0, 1, 4, 1, 5'b00011, 1, 0);
        step(1, 1, 0, 0); expect_dut("t3_b1", 0, 0, 0, 1, 5'b00111, 1, 0);
        step(1, 0, 0, 0); expect_dut("t3_b2", 0, 0, 1, 1, 5'b01110, 1, 0);
        step(1, 1, 0, 0); expect_dut("t3_b3", 0, 0, 0, 1, 5'b11101, 1, 0);
        step(1, 1, 0, 0); expect_dut("t3_b4", 0, 0, 0, 1, 5'b11011, 1, 0);

        // ---- 2. Overlap vs no overlap on 1011011 ----
        do_reset();
        s2m = '{1, 2, 3, 4, 2, 3, 4};
        s2n = '{1, 2, 3, 4, 0, 1, 1};
        begin
            logic [6:0] bits;
            bits = 7'b1011011;
            for (int i = 0; i < 7; i++) begin
                step(1, bits[6-i], 0, 0);
                expect_dut($sformatf("t2_ovl_e%0d", i + 1), 0, (i == 3 || i == 6), s2m[i],
                           (i < 3) ? 0 : ((i < 6) ? 1 : 2), 0, 0, 0);
                expect_dut($sformatf("t2_noovl_e%0d", i + 1), 1, (i == 3), s2n[i],
                           (i < 3) ? 0 : 1, 0, 0, 0);
            end
        end
        expect_dut("t2_stack_main", 0, 1, 4, 2, 5'b11011, 1, 0);
        expect_dut("t2_stack_noovl", 1, 0, 1, 1, 5'b11011, 1, 0);

        // ---- 4. Enable gap ----
        do_reset();
        step(1, 1, 0, 0); expect_dut("t4_e1", 0, 0, 1, 0, 5'b00001, 1, 0);
        step(1, 0, 0, 0); expect_dut("t4_e2", 0, 0, 2, 0, 5'b00010, 1, 0);
        step(0, 1, 0, 0); expect_dut("t4_gap1", 0, 0, 2, 0, 5'b00010, 1, 0);
        step(0, 0, 0, 0); expect_dut("t4_gap2", 0, 0, 2, 0, 5'b00010, 1, 0);
        step(0, 1, 0, 0); expect_dut("t4_gap3", 0, 0, 2, 0, 5'b00010, 1, 0);
        step(1, 1, 0, 0); expect_dut("t4_e3", 0, 0, 3, 0, 5'b00101, 1, 0);
        step(1, 1, 0, 0); expect_dut("t4_e4", 0, 1, 4, 1, 5'b01011, 1, 0);
        step(0, 0, 0, 0); expect_dut("t4_hold_out1", 0, 1, 4, 1, 5'b01011, 1, 0);
        step(0, 1, 0, 0); expect_dut("t4_hold_out2", 0, 1, 4, 1, 5'b01011, 1, 0);

        // ---- 5. Saturation: 2-bit counter, pattern 1111, ten ones ----
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            int c;
            c = (i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3);
            step(1, 1, 0, 0);
            expect_dut($sformatf("t5_sat_e%0d", i), 2, (i >= 4), (i < 4) ? i : 4, c,
                       (1 << ((i < 5) ? i : 5)) - 1, 1, (c == 3));
        end

        // ---- 6. Asynchronous reset mid-sequence ----
        do_reset();
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        expect_dut("t6_pre", 0, 0, 3, 1, 5'b01101, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        expect_dut("t6_async_main", 0, 0, 0, 0, 0, 1, 0);
        expect_dut("t6_async_sat", 2, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0, 0); expect_dut("t6_post1", 0, 0, 0, 0, 5'b00000, 1, 0);
        step(1, 1, 0, 0); expect_dut("t6_post2", 0, 0, 1, 0, 5'b00001, 1, 0);
        step(1, 1, 0, 0); expect_dut("t6_post3", 0, 0, 1, 0, 5'b00011, 1, 0);

        #3;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
